// File: rtl/nios_system_nios2_processor_mul_pkg.sv
// Shared types and constants for the iterative 32x32 multiply sequencer.
package nios_system_nios2_processor_mul_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned HALF_W  = 16;
    localparam int unsigned PROD_W  = 64;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned SHIFT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CORR  = 3'd3,
        ST_DONE  = 3'd4
    } mul_state_e;

    localparam logic [1:0] MUL_OP_LO  = 2'b00;
    localparam logic [1:0] MUL_OP_XUU = 2'b01;
    localparam logic [1:0] MUL_OP_XSU = 2'b10;
    localparam logic [1:0] MUL_OP_XSS = 2'b11;

    // Weight of the partial product issued at a given step.
    function automatic logic [SHIFT_W-1:0] pp_shift(input logic [CNT_W-1:0] cnt);
        case (cnt)
            2'd0:    pp_shift = SHIFT_W'(0);
            2'd3:    pp_shift = SHIFT_W'(32);
            default: pp_shift = SHIFT_W'(16);
        endcase
    endfunction

endpackage

// File: rtl/nios_system_nios2_processor_mul16_cell.sv
// 16x16 unsigned multiplier with a single output register.
module nios_system_nios2_processor_mul16_cell
    import nios_system_nios2_processor_mul_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [DATA_W-1:0]   p
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p <= '0;
        end else begin
            p <= DATA_W'(a) * DATA_W'(b);
        end
    end

endmodule

// File: rtl/nios_system_nios2_processor_mul_seq.sv
// Iterative 32x32 multiply: four 16x16 partial products through one cell,
// 64-bit accumulation, then signed correction of the upper word.
module nios_system_nios2_processor_mul_seq
    import nios_system_nios2_processor_mul_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [DATA_W-1:0]   in_src1,
    input  logic [DATA_W-1:0]   in_src2,
    input  logic                kill,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_result
);

    if (MUL_LATENCY != 1) begin : g_bad_latency
        $error("nios_system_nios2_processor_mul_seq: only MUL_LATENCY=1 is supported");
    end

    mul_state_e             r_state;
    mul_state_e             w_next_state;
    logic [1:0]             r_op;
    logic [DATA_W-1:0]      r_a;
    logic [DATA_W-1:0]      r_b;
    logic [CNT_W-1:0]       r_cnt;
    logic [PROD_W-1:0]      r_prod;
    logic                   r_acc_en;
    logic [SHIFT_W-1:0]     r_acc_sh;
    logic [DATA_W-1:0]      r_result;
    logic                   r_out_valid;
    logic [HALF_W-1:0]      w_cell_a;
    logic [HALF_W-1:0]      w_cell_b;
    logic [DATA_W-1:0]      w_pp;
    logic [DATA_W-1:0]      w_hi_corr;

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_result;

    // cnt bit 0 selects the upper half of A, bit 1 the upper half of B.
    assign w_cell_a = r_cnt[0] ? r_a[DATA_W-1:HALF_W] : r_a[HALF_W-1:0];
    assign w_cell_b = r_cnt[1] ? r_b[DATA_W-1:HALF_W] : r_b[HALF_W-1:0];

    nios_system_nios2_processor_mul16_cell u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (w_cell_a),
        .b       (w_cell_b),
        .p       (w_pp)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next_state = ST_ISSUE;
            ST_ISSUE: if (r_cnt == CNT_W'(3)) w_next_state = ST_DRAIN;
            ST_DRAIN: w_next_state = ST_CORR;
            ST_CORR:  w_next_state = ST_DONE;
            ST_DONE:  if (out_ready) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
        if (kill && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
        end
    end

    // Unsigned high word corrected for two's-complement operands.
    always_comb begin
        w_hi_corr = r_prod[PROD_W-1:DATA_W];
        if (((r_op == MUL_OP_XSU) || (r_op == MUL_OP_XSS)) && r_a[DATA_W-1]) begin
            w_hi_corr = w_hi_corr - r_b;
        end
        if ((r_op == MUL_OP_XSS) && r_b[DATA_W-1]) begin
            w_hi_corr = w_hi_corr - r_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_prod      <= '0;
            r_acc_en    <= 1'b0;
            r_acc_sh    <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_next_state == ST_DONE);
            r_acc_en    <= (r_state == ST_ISSUE);
            r_acc_sh    <= pp_shift(r_cnt);
            if (r_acc_en) begin
                r_prod <= r_prod + (PROD_W'(w_pp) << r_acc_sh);
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == ST_CORR) && !kill) begin
                r_result <= (r_op == MUL_OP_LO) ? r_prod[DATA_W-1:0] : w_hi_corr;
            end
            // Accept wins over a stale accumulate left behind by a kill.
            if ((r_state == ST_IDLE) && in_valid) begin
                r_op   <= in_op;
                r_a    <= in_src1;
                r_b    <= in_src2;
                r_cnt  <= '0;
                r_prod <= '0;
            end
        end
    end

endmodule
